// File: rtl/regfile_wb_arbiter.sv
// Writeback controller: arbitrates the ALU and load unit onto the register file's
// single write port and keeps a per-register pending-write scoreboard. Define RR_ARB_EN for round-robin.
module regfile_wb_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            claim_valid,
  input  logic [4:0]      claim_rd,
  output logic            claim_ready,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  output logic            wen,
  output logic [4:0]      waddr,
  output logic [XLEN-1:0] wdata
);

  // Handshake: a requester's {rd, data} is consumed in any cycle where valid && ready;
  // requesters hold valid/rd/data stable until then, and ready never depends on ready.

  logic [31:0]     busy_q;
  logic [31:0]     busy_nxt;
  logic            grant_alu;
  logic            grant_mem;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  assign claim_ready = (claim_rd == 5'd0) || !busy_q[claim_rd];
  assign rs1_busy    = busy_q[rs1];
  assign rs2_busy    = busy_q[rs2];

`ifdef RR_ARB_EN
  logic last_alu;

  always_comb begin
    grant_mem = mem_valid && (!alu_valid || last_alu);
    grant_alu = alu_valid && !grant_mem;
  end

  // Pointer starts at ALU-last so the load unit wins the first contention.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_alu <= 1'b1;
    end else if (grant_alu) begin
      last_alu <= 1'b1;
    end else if (grant_mem) begin
      last_alu <= 1'b0;
    end
  end
`else
  always_comb begin
    grant_mem = mem_valid;
    grant_alu = alu_valid && !mem_valid;
  end
`endif

  assign alu_ready = grant_alu;
  assign mem_ready = grant_mem;

  always_comb begin
    wb_rd   = alu_rd;
    wb_data = alu_data;
    if (grant_mem) begin
      wb_rd   = mem_rd;
      wb_data = mem_data;
    end
  end

  // A handshake to x0 is consumed without touching the write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wen   <= 1'b0;
      waddr <= 5'd0;
      wdata <= '0;
    end else begin
      wen <= 1'b0;
      if ((grant_alu || grant_mem) && (wb_rd != 5'd0)) begin
        wen   <= 1'b1;
        waddr <= wb_rd;
        wdata <= wb_data;
      end
    end
  end

  // The clear lands on the same edge the register file absorbs the write; a claim to
  // the register being cleared is refused by claim_ready, so set and clear never collide.
  always_comb begin
    busy_nxt = busy_q;
    if (wen) begin
      busy_nxt[waddr] = 1'b0;
    end
    if (claim_valid && claim_ready) begin
      busy_nxt[claim_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_nxt;
    end
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Writeback controller for the 32x32 two-read/one-write register file. It shares the register file's single write port between the ALU and load/store writeback requesters. It also keeps a per-register pending-write scoreboard, so the issue stage can stall on read-after-write and write-after-write hazards. It sits between the execute/memory stages and the register file's wen/waddr/wdata inputs.

## Interface
- XLEN, 32, data width of writeback payloads and wdata.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- claim_valid  in  1  issue stage reserves claim_rd for a future writeback.
- claim_rd  in  5  destination register being reserved.
- claim_ready  out  1  high when the claim can be accepted; combinational.
- rs1, rs2  in  5  source registers of the instruction in issue.
- rs1_busy, rs2_busy  out  1  pending write to rs1/rs2; combinational; x0 never busy.
- alu_valid  in  1  ALU writeback request.
- alu_rd  in  5  ALU writeback destination.
- alu_data  in  XLEN  ALU writeback value.
- alu_ready  out  1  ALU request granted this cycle.
- mem_valid, mem_rd, mem_data, mem_ready: same as alu_*, for the load unit.
- wen  out  1  registered write enable to the register file.
- waddr  out  5  registered write address.
- wdata  out  XLEN  registered write data.

## Operation
- Scoreboard: a 32-bit busy vector; bit 0 is hardwired 0.
- Claims:
  - claim_ready = claim_rd==0 || !busy[claim_rd]. A busy destination is a write-after-write stall.
  - A claim with claim_valid && claim_ready sets busy[claim_rd] at the clock edge. A claim to rd 0 is accepted with no effect.
- Arbitration: each cycle, at most one of alu_ready/mem_ready is high, and only for a requester with valid high.
  - A handshake (valid && ready) consumes that requester's {rd, data}.
  - The arbiter grants combinationally from the valid inputs. Requesters hold valid, rd and data stable until ready.
- Write port:
  - A handshake in cycle N registers wen=1, waddr=rd, wdata=data for cycle N+1.
  - With no handshake, wen=0; waddr and wdata hold their last values.
  - A handshake with rd==0 is consumed but wen stays 0.
- Scoreboard clear: when wen=1 in cycle N+1, busy[waddr] clears at the end of N+1.
  - The register file samples reads at that same edge, so busy covers every read that would see stale data.
- Simultaneous claim and clear of the same register: claim_ready is low, because the busy bit is still set that cycle. The clear takes effect and no new claim is made.
- A handshake to a non-busy register still writes. The scoreboard is unchanged.

## Timing
- Reset values: wen=0, waddr=0, wdata=0, busy=0, round-robin pointer=ALU-last (so mem wins first).
  - claim_ready=1 and rs*_busy=0 immediately on reset assertion.
- Reset mid-operation: any in-flight wen is dropped and all reservations are lost. The pipeline is flushed by the same reset.
- Latencies:
  - Handshake to wen: 1 cycle.
  - Handshake to busy clear visible on rs*_busy: 2 cycles.
  - Claim to busy visible: 1 cycle.
- Throughput: one writeback per cycle. A requester blocked by contention waits at most 1 cycle under round-robin.

## Configuration
- RR_ARB_EN defined: round-robin arbitration. When both requesters are valid, the one not granted most recently wins. The pointer updates only on a handshake.
- RR_ARB_EN undefined: fixed priority, mem over alu. The ALU can starve while mem_valid stays high. There is no pointer register.

## Test plan
- Reset and claim:
  - Assert reset mid-stream with busy[5]=1 and wen=1 -> wen=0, rs1_busy=0 for rs1=5, claim_ready=1.
  - Claim rd=5 -> next cycle rs1=5 gives rs1_busy=1, and a second claim of rd 5 sees claim_ready=0.
- Single writeback: alu_valid, alu_rd=5, alu_data=0xDEADBEEF in cycle N.
  - alu_ready=1 in N.
  - wen=1, waddr=5, wdata=0xDEADBEEF in N+1.
  - rs1_busy for rs1=5 is 1 in N+1 and 0 in N+2.
- Contention, both requesters valid for 3 cycles (alu rd=1, mem rd=2):
  - With RR_ARB_EN: grants mem, alu, mem.
  - Without RR_ARB_EN: grants mem, mem, mem and alu_ready stays 0.
- x0 writes:
  - mem handshake with rd=0 -> mem_ready=1, wen stays 0.
  - claim rd=0 -> claim_ready=1, and rs1=0 gives rs1_busy=0.
- Clear/claim collision: busy[7] set, wen=1 with waddr=7, claim_rd=7 in the same cycle.
  - claim_ready=0 that cycle.
  - busy[7]=0 next cycle.
  - A retried claim next cycle is accepted.
- Back-to-back: alu writes rd 3 with 0x1, then 0x2 on consecutive cycles -> two consecutive wen pulses with wdata 0x1 then 0x2.
